// File: rtl/pipeline_pkg.sv
// Shared pipeline declarations: MEM-stage FSM encoding, default timeout, holding-register layout.
// Latency: none; types, constants and a helper function only.
// Backpressure: none.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Fields of a memory op frozen while it is in flight.
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        we;
        logic        memtoreg;
        logic        regwrite;
    } mem_hold_t;

    // Data memory is accessed as 64-bit doublewords only.
    function automatic logic is_misaligned(input logic [63:0] addr);
        return addr[2:0] != 3'b000;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: captures a completed MEM result or inserts a bubble.
// Latency: 1 cycle from load/bubble to the q_* outputs.
// Backpressure: none; load wins over bubble, and with neither asserted the contents hold.
module memwb_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        d_valid,
    input  logic        d_memtoreg,
    input  logic        d_regwrite,
    input  logic [4:0]  d_rd,
    input  logic [63:0] d_alu_result,
    input  logic [63:0] d_rdata,
    output logic        q_valid,
    output logic        q_memtoreg,
    output logic        q_regwrite,
    output logic [4:0]  q_rd,
    output logic [63:0] q_alu_result,
    output logic [63:0] q_rdata
);

    // A bubble clears only what makes the slot live; data fields are don't-care then.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid      <= 1'b0;
            q_memtoreg   <= 1'b0;
            q_regwrite   <= 1'b0;
            q_rd         <= '0;
            q_alu_result <= '0;
            q_rdata      <= '0;
        end else if (load) begin
            q_valid      <= d_valid;
            q_memtoreg   <= d_memtoreg;
            q_regwrite   <= d_regwrite;
            q_rd         <= d_rd;
            q_alu_result <= d_alu_result;
            q_rdata      <= d_rdata;
        end else if (bubble) begin
            q_valid      <= 1'b0;
            q_regwrite   <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to data memory and fills the MEM/WB register.
// Latency: 1 cycle for non-memory ops; memory ops stall until handshake/response/timeout.
// Backpressure: valid/ready request channel; stall freezes upstream stages while an access is open.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_valid,
    input  logic [63:0] exmem_alu_result,
    input  logic [63:0] exmem_wdata,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_memread,
    input  logic        exmem_memwrite,
    input  logic        exmem_memtoreg,
    input  logic        exmem_regwrite,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata,
    output logic        memwb_valid,
    output logic        memwb_memtoreg,
    output logic        memwb_regwrite,
    output logic [4:0]  memwb_rd,
    output logic [63:0] memwb_alu_result,
    output logic [63:0] memwb_rdata,
    output logic        misalign_err,
    output logic        timeout_err
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_hold_t        hold_q;
    logic             capture;
    logic             misalign_d, timeout_d;
    logic             mem_op;
    logic             wb_load, wb_bubble;
    logic             wb_valid, wb_memtoreg, wb_regwrite;
    logic [4:0]       wb_rd;
    logic [63:0]      wb_alu_result, wb_rdata;

    assign mem_op        = exmem_valid & (exmem_memread | exmem_memwrite);
    assign mem_req_addr  = hold_q.addr;
    assign mem_req_wdata = hold_q.wdata;
    assign mem_req_we    = hold_q.we;

    // Next state, stall, request valid and what the MEM/WB register takes this edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        capture       = 1'b0;
        misalign_d    = 1'b0;
        timeout_d     = 1'b0;
        wb_load       = 1'b0;
        wb_bubble     = 1'b0;
        wb_valid      = 1'b1;
        wb_memtoreg   = hold_q.memtoreg;
        wb_regwrite   = hold_q.regwrite;
        wb_rd         = hold_q.rd;
        wb_alu_result = hold_q.addr;
        wb_rdata      = '0;
        case (state_q)
            IDLE: begin
                wb_valid      = exmem_valid;
                wb_memtoreg   = exmem_memtoreg;
                wb_regwrite   = exmem_regwrite;
                wb_rd         = exmem_rd;
                wb_alu_result = exmem_alu_result;
                if (mem_op && is_misaligned(exmem_alu_result)) begin
                    // Dropped access retires without a register write.
                    wb_load     = 1'b1;
                    wb_regwrite = 1'b0;
                    misalign_d  = 1'b1;
                end else if (mem_op) begin
                    stall     = 1'b1;
                    capture   = 1'b1;
                    wb_bubble = 1'b1;
                    state_d   = REQ;
                end else if (exmem_valid) begin
                    wb_load = 1'b1;
                end else begin
                    wb_bubble = 1'b1;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready && hold_q.we) begin
                    wb_load = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    if (mem_req_ready) begin
                        cnt_d   = '0;
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    wb_load  = 1'b1;
                    wb_rdata = mem_rsp_rdata;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandoned load retires without a register write.
                    wb_load     = 1'b1;
                    wb_regwrite = 1'b0;
                    timeout_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, wait counter and single-cycle error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            misalign_err <= misalign_d;
            timeout_err  <= timeout_d;
        end
    end

    // Freeze the memory op on entry to REQ; write wins when both read and write are set.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q.addr     <= exmem_alu_result;
            hold_q.wdata    <= exmem_wdata;
            hold_q.rd       <= exmem_rd;
            hold_q.we       <= exmem_memwrite;
            hold_q.memtoreg <= exmem_memtoreg;
            hold_q.regwrite <= exmem_regwrite;
        end
    end

    memwb_reg u_memwb_reg (
        .clk          (clk),
        .reset        (reset),
        .load         (wb_load),
        .bubble       (wb_bubble),
        .d_valid      (wb_valid),
        .d_memtoreg   (wb_memtoreg),
        .d_regwrite   (wb_regwrite),
        .d_rd         (wb_rd),
        .d_alu_result (wb_alu_result),
        .d_rdata      (wb_rdata),
        .q_valid      (memwb_valid),
        .q_memtoreg   (memwb_memtoreg),
        .q_regwrite   (memwb_regwrite),
        .q_rd         (memwb_rd),
        .q_alu_result (memwb_alu_result),
        .q_rdata      (memwb_rdata)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random back-to-back instructions.
// Latency: outputs checked 1 ns after the completion edge, stall/request at the falling edge.
// Backpressure: bench acts as data memory with per-access ready delay and response delay.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        exmem_valid;
    logic [63:0] exmem_alu_result;
    logic [63:0] exmem_wdata;
    logic [4:0]  exmem_rd;
    logic        exmem_memread, exmem_memwrite, exmem_memtoreg, exmem_regwrite;
    logic        stall;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        memwb_valid, memwb_memtoreg, memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [63:0] memwb_alu_result, memwb_rdata;
    logic        misalign_err, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .exmem_valid      (exmem_valid),
        .exmem_alu_result (exmem_alu_result),
        .exmem_wdata      (exmem_wdata),
        .exmem_rd         (exmem_rd),
        .exmem_memread    (exmem_memread),
        .exmem_memwrite   (exmem_memwrite),
        .exmem_memtoreg   (exmem_memtoreg),
        .exmem_regwrite   (exmem_regwrite),
        .stall            (stall),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_we       (mem_req_we),
        .mem_req_addr     (mem_req_addr),
        .mem_req_wdata    (mem_req_wdata),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_rdata    (mem_rsp_rdata),
        .memwb_valid      (memwb_valid),
        .memwb_memtoreg   (memwb_memtoreg),
        .memwb_regwrite   (memwb_regwrite),
        .memwb_rd         (memwb_rd),
        .memwb_alu_result (memwb_alu_result),
        .memwb_rdata      (memwb_rdata),
        .misalign_err     (misalign_err),
        .timeout_err      (timeout_err)
    );

    typedef struct {
        logic        vld;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        rd_en;
        logic        wr_en;
        logic        m2r;
        logic        rw;
    } ins_t;

    task automatic drive_ins(input ins_t i);
        exmem_valid      = i.vld;
        exmem_alu_result = i.alu;
        exmem_wdata      = i.wdata;
        exmem_rd         = i.rd;
        exmem_memread    = i.rd_en;
        exmem_memwrite   = i.wr_en;
        exmem_memtoreg   = i.m2r;
        exmem_regwrite   = i.rw;
    endtask

    task automatic drive_idle();
        exmem_valid      = 1'b0;
        exmem_alu_result = {$urandom, $urandom};
        exmem_wdata      = {$urandom, $urandom};
        exmem_rd         = 5'($urandom);
        exmem_memread    = 1'($urandom);
        exmem_memwrite   = 1'($urandom);
        exmem_memtoreg   = 1'($urandom);
        exmem_regwrite   = 1'($urandom);
    endtask

    // Present one instruction, act as memory, and check timing and the retired result.
    // sdly = cycles from read handshake to response; 0 means the memory never answers.
    task automatic run_ins(input ins_t i, input int rdly, input int sdly,
                           input logic [63:0] rsp_dat, input string tag);
        bit is_mem, is_mis;
        int exp_stall, exp_req, exp_hs;
        bit exp_vld, exp_rw, exp_mis, exp_to;
        logic [63:0] exp_rdata;
        int n_stall, n_req, n_hs, cyc, since;
        bit waiting, done, req_ok, bub_ok;

        // Reference outcome from the stage's rules.
        is_mem    = i.vld && (i.rd_en || i.wr_en);
        is_mis    = is_mem && (i.alu % 8 != 0);
        exp_stall = 0; exp_req = 0; exp_hs = 0;
        exp_vld   = i.vld; exp_rw = i.vld && i.rw;
        exp_mis   = 0; exp_to = 0; exp_rdata = 64'd0;
        if (is_mis) begin
            exp_vld = 1; exp_rw = 0; exp_mis = 1;
        end else if (is_mem && i.wr_en) begin
            exp_stall = 1 + rdly; exp_req = rdly + 1; exp_hs = 1;
            exp_vld = 1; exp_rw = i.rw;
        end else if (is_mem) begin
            exp_req = rdly + 1; exp_hs = 1; exp_vld = 1;
            if (sdly >= 1 && sdly <= TO) begin
                exp_stall = 1 + rdly + sdly; exp_rw = i.rw; exp_rdata = rsp_dat;
            end else begin
                exp_stall = 1 + rdly + TO; exp_rw = 0; exp_to = 1;
            end
        end

        n_stall = 0; n_req = 0; n_hs = 0; cyc = 0; since = 0;
        waiting = 0; done = 0; req_ok = 1; bub_ok = 1;
        drive_ins(i);
        while (!done && cyc < 40) begin
            if (waiting) since++;
            mem_req_ready = (n_req >= rdly);
            if (waiting) begin
                mem_rsp_valid = (since == sdly);
                mem_rsp_rdata = (since == sdly) ? rsp_dat : {$urandom, $urandom};
            end else begin
                mem_rsp_valid = 1'($urandom);
                mem_rsp_rdata = {$urandom, $urandom};
            end
            @(negedge clk);
            if (stall === 1'b1) n_stall++;
            if (cyc > 0 && (memwb_valid !== 1'b0 || memwb_regwrite !== 1'b0)) bub_ok = 0;
            if (mem_req_valid === 1'b1) begin
                n_req++;
                if (mem_req_addr !== i.alu || mem_req_we !== i.wr_en ||
                    (i.wr_en && mem_req_wdata !== i.wdata)) req_ok = 0;
                if (mem_req_ready) begin
                    n_hs++;
                    if (mem_req_we === 1'b0) begin waiting = 1; since = 0; end
                end
            end
            if (stall !== 1'b1) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        mem_rsp_valid = 1'b0;

        checks++;
        if (!done) begin errors++; $display("FAIL %s completion got none exp within 40 cycles", tag); end
        checks++;
        if (n_stall != exp_stall) begin errors++; $display("FAIL %s stall_cycles got %0d exp %0d", tag, n_stall, exp_stall); end
        checks++;
        if (n_req != exp_req) begin errors++; $display("FAIL %s req_cycles got %0d exp %0d", tag, n_req, exp_req); end
        checks++;
        if (n_hs != exp_hs) begin errors++; $display("FAIL %s handshakes got %0d exp %0d", tag, n_hs, exp_hs); end
        checks++;
        if (!req_ok) begin errors++; $display("FAIL %s req_stable got 0 exp 1", tag); end
        checks++;
        if (!bub_ok) begin errors++; $display("FAIL %s bubble_while_stalled got 0 exp 1", tag); end
        checks++;
        if (memwb_valid !== exp_vld) begin errors++; $display("FAIL %s memwb_valid got %b exp %b", tag, memwb_valid, exp_vld); end
        checks++;
        if (memwb_regwrite !== exp_rw) begin errors++; $display("FAIL %s memwb_regwrite got %b exp %b", tag, memwb_regwrite, exp_rw); end
        if (exp_vld) begin
            checks++;
            if (memwb_rd !== i.rd) begin errors++; $display("FAIL %s memwb_rd got %0d exp %0d", tag, memwb_rd, i.rd); end
            checks++;
            if (memwb_alu_result !== i.alu) begin errors++; $display("FAIL %s memwb_alu_result got %h exp %h", tag, memwb_alu_result, i.alu); end
            checks++;
            if (memwb_memtoreg !== i.m2r) begin errors++; $display("FAIL %s memwb_memtoreg got %b exp %b", tag, memwb_memtoreg, i.m2r); end
            checks++;
            if (memwb_rdata !== exp_rdata) begin errors++; $display("FAIL %s memwb_rdata got %h exp %h", tag, memwb_rdata, exp_rdata); end
        end
        checks++;
        if (misalign_err !== exp_mis) begin errors++; $display("FAIL %s misalign_err got %b exp %b", tag, misalign_err, exp_mis); end
        checks++;
        if (timeout_err !== exp_to) begin errors++; $display("FAIL %s timeout_err got %b exp %b", tag, timeout_err, exp_to); end
    endtask

    // One idle slot: stage must be free, errors must have dropped after one cycle.
    task automatic idle_check(input string tag);
        drive_idle();
        mem_rsp_valid = 1'($urandom);
        mem_rsp_rdata = {$urandom, $urandom};
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL %s idle_stall_req got %b%b exp 00", tag, stall, mem_req_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (memwb_valid !== 1'b0 || misalign_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL %s idle_wb_err got %b%b%b exp 000", tag, memwb_valid, misalign_err, timeout_err);
        end
        mem_rsp_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({stall, mem_req_valid, mem_req_we, memwb_valid, memwb_memtoreg, memwb_regwrite,
             misalign_err, timeout_err} !== 8'd0 || memwb_rd !== 5'd0 ||
            memwb_alu_result !== 64'd0 || memwb_rdata !== 64'd0 ||
            mem_req_addr !== 64'd0 || mem_req_wdata !== 64'd0) begin
            errors++;
            $display("FAIL %s outputs_zero got stall=%b req=%b wbv=%b rw=%b rd=%0d alu=%h rdata=%h mis=%b to=%b exp all 0",
                     tag, stall, mem_req_valid, memwb_valid, memwb_regwrite, memwb_rd,
                     memwb_alu_result, memwb_rdata, misalign_err, timeout_err);
        end
    endtask

    function automatic ins_t mk(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                                input logic r, input logic w, input logic m2r, input logic rw);
        ins_t i;
        i.vld = 1'b1; i.alu = alu; i.wdata = wd; i.rd = rd;
        i.rd_en = r; i.wr_en = w; i.m2r = m2r; i.rw = rw;
        return i;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
    endtask

    task automatic test_alu();
        run_ins(mk(64'h2A, 64'h0, 5'd5, 0, 0, 0, 1), 0, 0, 64'd0, "alu");
    endtask

    task automatic test_load();
        run_ins(mk(64'h100, 64'h0, 5'd7, 1, 0, 1, 1), 0, 3, 64'hDEADBEEF, "load");
        idle_check("load_after");
    endtask

    task automatic test_store();
        run_ins(mk(64'h108, 64'h55, 5'd0, 0, 1, 0, 0), 2, 0, 64'd0, "store");
        run_ins(mk(64'h110, 64'hABCD, 5'd3, 1, 1, 0, 0), 1, 1, 64'h1234, "store_rw_both");
        idle_check("store_after");
    endtask

    task automatic test_misalign();
        run_ins(mk(64'h103, 64'h0, 5'd9, 1, 0, 1, 1), 0, 1, 64'h77, "misalign");
        idle_check("misalign_after");
    endtask

    task automatic test_timeout();
        run_ins(mk(64'h200, 64'h0, 5'd11, 1, 0, 1, 1), 1, 0, 64'd0, "timeout");
        idle_check("timeout_after");
        run_ins(mk(64'h208, 64'h0, 5'd12, 1, 0, 1, 1), 0, TO, 64'hCAFE, "rsp_at_limit");
    endtask

    task automatic test_reset_mid_access();
        // Reset while waiting for a response, then a late response.
        drive_ins(mk(64'h300, 64'h0, 5'd13, 1, 0, 1, 1));
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
            check_all_zero("reset_wait_rsp");
        end
        mem_rsp_valid = 1'b0;
        // Reset while a request is still waiting for ready.
        drive_ins(mk(64'h308, 64'h99, 5'd14, 0, 1, 0, 0));
        mem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_req");
        run_ins(mk(64'h40, 64'h0, 5'd1, 0, 0, 0, 1), 0, 0, 64'd0, "post_reset_alu");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            ins_t i;
            int k;
            i = mk({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 0, 0, 0, 1'($urandom));
            i.alu = i.alu - (i.alu % 8);
            k = $urandom_range(0, 4);
            case (k)
                0: ;
                1: begin i.rd_en = 1; i.m2r = 1; i.rw = 1; end
                2: begin i.wr_en = 1; i.rd_en = 1'($urandom); i.rw = 0; end
                3: begin i.vld = 0; i.rd_en = 1'($urandom); i.wr_en = 1'($urandom); end
                default: begin
                    i.alu = i.alu + 64'($urandom_range(1, 7));
                    i.rd_en = 1'($urandom); i.wr_en = !i.rd_en; i.m2r = i.rd_en;
                end
            endcase
            run_ins(i, $urandom_range(0, 3), $urandom_range(0, TO + 2),
                    {$urandom, $urandom}, $sformatf("rand%0d", n));
        end
        idle_check("rand_after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
